// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant locking; grant passes on done or owner withdrawal.
// Define ARB_TIMEOUT_EN to force a release (and pulse timeout) once an owner has held MAX_HOLD cycles.
module rr_arbiter4 #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] grant,
   output logic [1:0] grant_id,
   output logic       busy,
   output logic       timeout
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   generate
      if (MAX_HOLD < 2 || MAX_HOLD > 255 || (MAX_HOLD >> CNT_W) != 0) begin : g_bad_cfg
         $error("rr_arbiter4: MAX_HOLD must be 2..255 and fit in CNT_W bits");
      end
   endgenerate

   logic [0:0]       state_q,    state_d;
   logic [1:0]       last_ptr_q, last_ptr_d;
   logic [3:0]       grant_q,    grant_d;
   logic [1:0]       grant_id_q, grant_id_d;
   logic             busy_q,     busy_d;
   logic             timeout_q,  timeout_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

   logic [3:0] pick_req;
   logic [1:0] pick_idx;
   logic [1:0] pick_id;
   logic       pick_found;
   logic [3:0] pick_onehot;
   logic       owner_req;
   logic       to_hit;
   logic       release_now;

`ifdef ARB_TIMEOUT_EN
   assign to_hit = (state_q == ST_BUSY) && (hold_cnt_q == CNT_W'(MAX_HOLD));
`else
   assign to_hit = 1'b0;
`endif

   assign owner_req   = req[grant_id_q];
   assign release_now = done || !owner_req || to_hit;

   // In BUSY the owner is masked out so any other requester wins first.
   always_comb begin
      pick_req = req;
      if (state_q == ST_BUSY) begin
         pick_req = req & ~grant_q;
      end
   end

   // Rotated priority search: last_ptr+1, +2, +3, then last_ptr itself.
   always_comb begin
      pick_id    = 2'd0;
      pick_found = 1'b0;
      pick_idx   = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         pick_idx = last_ptr_q + 2'(k);
         if (!pick_found && pick_req[pick_idx]) begin
            pick_id    = pick_idx;
            pick_found = 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_dec
         assign pick_onehot[gi] = (pick_id == 2'(gi));
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      last_ptr_d = last_ptr_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      busy_d     = busy_q;
      timeout_d  = 1'b0;
      hold_cnt_d = hold_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d    = ST_BUSY;
               grant_d    = pick_onehot;
               grant_id_d = pick_id;
               last_ptr_d = pick_id;
               busy_d     = 1'b1;
               hold_cnt_d = CNT_ONE;
            end
         end
         default: begin
            if (release_now) begin
               timeout_d = to_hit;
               if (pick_found) begin
                  grant_d    = pick_onehot;
                  grant_id_d = pick_id;
                  last_ptr_d = pick_id;
                  hold_cnt_d = CNT_ONE;
               end else if (owner_req && done) begin
                  hold_cnt_d = CNT_ONE;
               end else begin
                  state_d    = ST_IDLE;
                  grant_d    = 4'b0000;
                  busy_d     = 1'b0;
                  hold_cnt_d = '0;
               end
            end else if (hold_cnt_q != CNT_MAX) begin
               hold_cnt_d = hold_cnt_q + CNT_ONE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         last_ptr_q <= 2'd3;
         grant_q    <= 4'b0000;
         grant_id_q <= 2'd0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         last_ptr_q <= last_ptr_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         busy_q     <= busy_d;
         timeout_q  <= timeout_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign grant    = grant_q;
   assign grant_id = grant_id_q;
   assign busy     = busy_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 with MAX_HOLD=4; timeout expectations follow ARB_TIMEOUT_EN.
module tb_rr_arbiter4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic       done;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic       busy;
   logic       timeout;

   int n_checks = 0;
   int n_fail   = 0;

   rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .done     (done),
      .grant    (grant),
      .grant_id (grant_id),
      .busy     (busy),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", tag, obs, exp);
      end else begin
         $display("ok   %s: %b", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 4'b0000;
      done  = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   logic [3:0] rr_seq [5];

   initial begin
      rr_seq[0] = 4'b0001;
      rr_seq[1] = 4'b0010;
      rr_seq[2] = 4'b0100;
      rr_seq[3] = 4'b1000;
      rr_seq[4] = 4'b0001;

      do_reset();
      check("reset grant",    8'(grant),    8'h00);
      check("reset grant_id", 8'(grant_id), 8'h00);
      check("reset busy",     8'(busy),     8'h00);
      check("reset timeout",  8'(timeout),  8'h00);

      // done while idle has no effect
      done = 1'b1;
      step();
      check("idle done grant", 8'(grant), 8'h00);
      check("idle done busy",  8'(busy),  8'h00);
      done = 1'b0;

      // first grant, then direct handoff on done
      req = 4'b0101;
      step();
      check("t1 grant",    8'(grant),    8'h01);
      check("t1 grant_id", 8'(grant_id), 8'h00);
      check("t1 busy",     8'(busy),     8'h01);
      done = 1'b1;
      step();
      done = 1'b0;
      check("t1 handoff grant",    8'(grant),    8'h04);
      check("t1 handoff grant_id", 8'(grant_id), 8'h02);
      check("t1 handoff busy",     8'(busy),     8'h01);
      req = 4'b0000;
      step();
      check("t1 drop grant", 8'(grant), 8'h00);
      check("t1 drop busy",  8'(busy),  8'h00);

      // full rotation, done every third cycle
      do_reset();
      req = 4'b1111;
      step();
      for (int i = 0; i < 5; i++) begin
         for (int c = 0; c < 3; c++) begin
            check($sformatf("rot owner%0d cyc%0d grant", i, c), 8'(grant), 8'(rr_seq[i]));
            check($sformatf("rot owner%0d cyc%0d timeout", i, c), 8'(timeout), 8'h00);
            done = (c == 2);
            step();
         end
      end
      done = 1'b0;
      check("rot next grant", 8'(grant), 8'h02);

      // owner 1 withdraws while 0 and 3 request: 3 wins
      req = 4'b1001;
      step();
      check("withdraw grant",    8'(grant),    8'h08);
      check("withdraw grant_id", 8'(grant_id), 8'h03);

      // sole requester re-granted on done
      req = 4'b0010;
      step();
      check("sole first grant", 8'(grant), 8'h02);
      for (int r = 0; r < 2; r++) begin
         done = 1'b1;
         step();
         check($sformatf("sole regrant%0d grant", r), 8'(grant), 8'h02);
         check($sformatf("sole regrant%0d busy", r),  8'(busy),  8'h01);
      end
      req = 4'b0000;
      step();
      done = 1'b0;
      check("sole release grant", 8'(grant), 8'h00);
      check("sole release busy",  8'(busy),  8'h00);

      // asynchronous reset between edges
      req = 4'b0100;
      step();
      check("pre-areset grant", 8'(grant), 8'h04);
      #2 reset = 1'b1;
      #1;
      check("areset grant", 8'(grant), 8'h00);
      check("areset busy",  8'(busy),  8'h00);
      req = 4'b1000;
      #3 reset = 1'b0;
      step();
      check("post-areset grant",    8'(grant),    8'h08);
      check("post-areset grant_id", 8'(grant_id), 8'h03);

      // hold limit
      do_reset();
      req = 4'b0011;
      step();
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("hold cyc%0d grant", k),   8'(grant),   8'h01);
         check($sformatf("hold cyc%0d timeout", k), 8'(timeout), 8'h00);
         step();
      end
`ifdef ARB_TIMEOUT_EN
      check("to grant",   8'(grant),   8'h02);
      check("to timeout", 8'(timeout), 8'h01);
      step();
      check("to after grant",   8'(grant),   8'h02);
      check("to after timeout", 8'(timeout), 8'h00);
`else
      check("no-to grant",   8'(grant),   8'h01);
      check("no-to timeout", 8'(timeout), 8'h00);
      step();
      check("no-to after grant",   8'(grant),   8'h01);
      check("no-to after timeout", 8'(timeout), 8'h00);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
